// File: rtl/operand_demux16.sv
// ---------------------------------------------------------------------------
// operand_demux16
//   Steers a 16-bit operand stream into one of two holding slots. The
//   destination is either chosen manually (s) or taken from an internal
//   pointer that alternates after every accepted word in auto mode. Each
//   slot holds its word until the downstream logic acknowledges it.
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous reset, active low
//   in_data     incoming operand word
//   in_valid    in_data is offered this cycle
//   in_ready    block accepts in_data this cycle (target slot is empty)
//   s           manual destination select (0 = slot 0, 1 = slot 1)
//   auto_mode   1 = destination comes from ptr, s is ignored
//   out0/out1   slot holding registers
//   out0_valid  slot 0 holds an unconsumed word
//   out1_valid  slot 1 holds an unconsumed word
//   out0_ack    downstream consumes slot 0
//   out1_ack    downstream consumes slot 1
//   pair_valid  both slots hold unconsumed words
//   ptr         current auto-mode destination
// ---------------------------------------------------------------------------
module operand_demux16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        s,
  input  logic        auto_mode,
  output logic [15:0] out0,
  output logic [15:0] out1,
  output logic        out0_valid,
  output logic        out1_valid,
  input  logic        out0_ack,
  input  logic        out1_ack,
  output logic        pair_valid,
  output logic        ptr
);

  logic [15:0] out0_r;
  logic [15:0] out1_r;
  logic        v0_r;
  logic        v1_r;
  logic        pv_r;
  logic        ptr_r;

  logic        tgt_s;
  logic        ready_s;
  logic        accept_s;
  logic        v0_nxt_s;
  logic        v1_nxt_s;
  logic        ptr_nxt_s;

  // Destination select and readiness; uses registered state only, so the
  // acks never reach in_ready combinationally.
  always_comb begin
    tgt_s    = 1'b0;
    ready_s  = 1'b0;
    accept_s = 1'b0;
    if (auto_mode) begin
      tgt_s = ptr_r;
    end else begin
      tgt_s = s;
    end
    if (tgt_s) begin
      ready_s = ~v1_r;
    end else begin
      ready_s = ~v0_r;
    end
    accept_s = in_valid & ready_s;
  end

  // Next-state of the slot valid flags and the pointer. An accept only
  // lands in an empty slot, so a set and a clear never target the same slot.
  always_comb begin
    v0_nxt_s  = v0_r;
    v1_nxt_s  = v1_r;
    ptr_nxt_s = ptr_r;
    if (v0_r && out0_ack) begin
      v0_nxt_s = 1'b0;
    end else if (accept_s && !tgt_s) begin
      v0_nxt_s = 1'b1;
    end else begin
      v0_nxt_s = v0_r;
    end
    if (v1_r && out1_ack) begin
      v1_nxt_s = 1'b0;
    end else if (accept_s && tgt_s) begin
      v1_nxt_s = 1'b1;
    end else begin
      v1_nxt_s = v1_r;
    end
    if (accept_s && auto_mode) begin
      ptr_nxt_s = ~ptr_r;
    end else begin
      ptr_nxt_s = ptr_r;
    end
  end

  // Slot registers, flags and pointer; pair_valid is registered from the
  // next-state flags so it lines up with the valid outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out0_r <= 16'h0000;
      out1_r <= 16'h0000;
      v0_r   <= 1'b0;
      v1_r   <= 1'b0;
      pv_r   <= 1'b0;
      ptr_r  <= 1'b0;
    end else begin
      if (accept_s && !tgt_s) begin
        out0_r <= in_data;
      end else begin
        out0_r <= out0_r;
      end
      if (accept_s && tgt_s) begin
        out1_r <= in_data;
      end else begin
        out1_r <= out1_r;
      end
      v0_r  <= v0_nxt_s;
      v1_r  <= v1_nxt_s;
      pv_r  <= v0_nxt_s & v1_nxt_s;
      ptr_r <= ptr_nxt_s;
    end
  end

  assign in_ready   = ready_s;
  assign out0       = out0_r;
  assign out1       = out1_r;
  assign out0_valid = v0_r;
  assign out1_valid = v1_r;
  assign pair_valid = pv_r;
  assign ptr        = ptr_r;

endmodule

// File: doc/operand_demux16.md
OPERAND_DEMUX16 -- requirements
Module: operand_demux16

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-002 The port `clk` SHALL be an input, 1 bit wide: the single clock, with all state updated on its rising edge.
REQ-003 The port `rst_n` SHALL be an input, 1 bit wide: asynchronous reset, active low.
REQ-004 The port `in_data` SHALL be an input, 16 bits wide: the incoming operand word.
REQ-005 The port `in_valid` SHALL be an input, 1 bit wide: `in_data` is offered this cycle.
REQ-006 The port `in_ready` SHALL be an output, 1 bit wide: the block accepts `in_data` this cycle.
REQ-007 The port `s` SHALL be an input, 1 bit wide: manual destination select, 0 = slot 0 and 1 = slot 1.
REQ-008 The port `auto_mode` SHALL be an input, 1 bit wide: 1 = the destination is taken from the internal alternating pointer and `s` is ignored.
REQ-009 The ports `out0` and `out1` SHALL be outputs, 16 bits wide each: the holding registers of slot 0 and slot 1.
REQ-010 The ports `out0_valid` and `out1_valid` SHALL be outputs, 1 bit wide each: the corresponding slot holds an unconsumed word.
REQ-011 The ports `out0_ack` and `out1_ack` SHALL be inputs, 1 bit wide each: the downstream logic consumes the corresponding slot.
REQ-012 The port `pair_valid` SHALL be an output, 1 bit wide: both slots are valid.
REQ-013 The port `ptr` SHALL be an output, 1 bit wide: the current auto-mode destination.

Function
REQ-014 The destination `tgt` SHALL be `ptr` when `auto_mode`=1 and `s` otherwise.
REQ-015 `in_ready` SHALL be combinational and SHALL equal NOT valid(tgt), computed from registered state only, with no combinational path from `outN_ack`.
REQ-016 An accept SHALL occur only when `in_valid` AND `in_ready` are both 1 on a rising clock edge.
REQ-017 On an accept, `out[tgt]` SHALL load `in_data` and `out[tgt]_valid` SHALL be 1 the following cycle, giving a latency of 1 cycle.
REQ-018 On an accept with `auto_mode`=1, `ptr` SHALL toggle.
REQ-019 On an accept with `auto_mode`=0, `ptr` SHALL be unchanged.
REQ-020 When `in_valid`=1 and `in_ready`=0, the block SHALL leave all slots and `ptr` unchanged, so the upstream holds its data.
REQ-021 When `outN_ack`=1 and `outN_valid`=1, `outN_valid` SHALL clear the next cycle and `outN` SHALL retain its value.
REQ-022 When `outN_ack`=1 and `outN_valid`=0, the block SHALL ignore the ack.
REQ-023 When an ack of slot N and an offer to slot N occur in the same cycle, there SHALL be no accept, because `in_ready` was 0; the slot SHALL clear, and the offer SHALL be accepted one cycle later at the earliest.
REQ-024 An accept into slot N and an ack of the other slot in the same cycle SHALL both take effect independently.
REQ-025 Acks of both slots in the same cycle SHALL clear both slots.
REQ-026 The slot state SHALL be {out1_valid, out0_valid}, with states EMPTY(00), HAS0(01), HAS1(10) and FULL(11); transitions SHALL be produced only by accepts (set) and acks (clear), as specified above.
REQ-027 `pair_valid` SHALL be 1 exactly in state FULL.
REQ-028 Toggling `auto_mode` mid-stream SHALL NOT alter `ptr`; auto mode SHALL resume from the retained `ptr`.
REQ-029 Changes of `s` SHALL take effect in the same cycle, on `tgt` and `in_ready`.
REQ-030 The data path SHALL be 16 bits, passed unmodified, with no arithmetic applied.

Reset
REQ-031 While `rst_n`=0, the block SHALL immediately (asynchronously) hold `out0`=0x0000, `out1`=0x0000, `out0_valid`=0, `out1_valid`=0, `pair_valid`=0 and `ptr`=0, independent of `clk`.
REQ-032 During reset, `in_ready` SHALL be 1, since the target slot is empty, but an accept SHALL NOT take effect while `rst_n`=0.
REQ-033 Reset asserted mid-operation SHALL discard all held words and the pointer.
REQ-034 The first edge after release SHALL behave as from EMPTY with `ptr`=0.

Verification
REQ-035 Manual load: `auto_mode`=0, `s`=0, offer 0x1234 for 1 cycle, then `s`=1, offer 0xABCD -> `out0`=0x1234 with `out0_valid`=1, then `out1`=0xABCD with `out1_valid`=1, then `pair_valid`=1; `ptr` stays 0.
REQ-036 Auto alternation: `auto_mode`=1, stream 0x0001, 0x0002, 0x0003 with ack of slot 0 after the 2nd word -> `out0`=0x0001 then `out1`=0x0002, `ptr` toggles 0->1->0, and the 3rd word lands in `out0`=0x0003 one cycle after the ack.
REQ-037 Backpressure: with `out0_valid`=1 and `s`=0, hold `in_valid`=1 with 0x5555 for 3 cycles -> `in_ready`=0, `out0` unchanged; ack slot 0 -> 0x5555 accepted exactly the next cycle.
REQ-038 Simultaneous events: ack of slot 1 together with an accept into slot 0 in one cycle -> the next cycle shows `out0_valid`=1 and `out1_valid`=0; acks on both slots together -> state EMPTY.
REQ-039 Spurious ack: `out1_ack`=1 while `out1_valid`=0 -> no state change, and `out1` retains its old value.
REQ-040 Mid-operation reset: in FULL with `ptr`=1, pulse `rst_n` low between clock edges -> all outputs zero immediately; after release, offer 0x00FF in auto mode -> it lands in `out0`.
